// File: rtl/lsu_bus_master_if.sv
// Pipeline request/response and RAM data-port signals of the LSU bus master.
// The master modport is the LSU's view; the slave modport is the pipeline/RAM side.
interface lsu_bus_master_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;
    logic              ce_o;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [3:0]        sel_o;
    logic [31:0]       data_o;
    logic              rvalid_i;
    logic [31:0]       data_i;

    modport master (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  rvalid_i, data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output ce_o, we_o, addr_o, sel_o, data_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output rvalid_i, data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  ce_o, we_o, addr_o, sel_o, data_o
    );
endinterface

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator driving a word-wide RAM port with byte enables.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses instead of flagging them.
module lsu_bus_master #(
    parameter int ADDR_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    lsu_bus_master_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction
`endif

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{~uns & raw[7]}}, raw[7:0]};
            2'b01:   r = {{16{~uns & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    state_t            state_r;
    logic              ready_r;
    logic              resp_valid_r;
    logic [31:0]       resp_rdata_r;
    logic              resp_err_r;
    logic              ce_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [3:0]        sel_r;
    logic [31:0]       data_r;
    logic              split_r;
    logic [1:0]        size_r;
    logic              uns_r;
    logic [1:0]        off_r;
    logic [ADDR_W-1:0] addr1_r;
    logic [3:0]        sel1_r;
    logic [31:0]       data1_r;
    logic [31:0]       first_r;

    logic [1:0]        off_s;
    logic [3:0]        mask_s;
    logic [7:0]        sel_wide_s;
    logic [63:0]       wshift_s;
    logic              aligned_s;
    logic              err_s;
    logic              split_s;
    logic [31:0]       wdata0_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [63:0]       rsrc_s;
    logic [31:0]       load_s;

    // Decode the incoming request: lane masks, lane-placed store data, error and split.
    always_comb begin
        off_s       = bus.req_addr_i[1:0];
        mask_s      = size_mask(bus.req_size_i);
        sel_wide_s  = {4'b0000, mask_s} << off_s;
        wshift_s    = {32'h0000_0000, bus.req_wdata_i} << {off_s, 3'b000};
        word_addr_s = {bus.req_addr_i[ADDR_W-1:2], 2'b00};
        aligned_s   = (bus.req_size_i == 2'b00) ||
                      ((bus.req_size_i == 2'b01) && !off_s[0]) ||
                      ((bus.req_size_i == 2'b10) && (off_s == 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
        err_s   = (bus.req_size_i == 2'b11);
        split_s = !err_s && (({1'b0, off_s} + size_nbytes(bus.req_size_i)) > 3'd4);
`else
        err_s   = (bus.req_size_i == 2'b11) || !aligned_s;
        split_s = 1'b0;
`endif
        // Replication is only lane-correct for naturally aligned data; an odd half
        // needs the shifted copy so the low byte lands in the lower lane.
        wdata0_s = !aligned_s                  ? wshift_s[31:0] :
                   (bus.req_size_i == 2'b00)   ? {4{bus.req_wdata_i[7:0]}} :
                   (bus.req_size_i == 2'b01)   ? {2{bus.req_wdata_i[15:0]}} :
                                                 bus.req_wdata_i;
    end

    // Align and extend returned read data; the second access supplies the upper bytes.
    always_comb begin
        rsrc_s = (state_r == ACC1) ? {bus.data_i, first_r} : {32'h0000_0000, bus.data_i};
        load_s = extend(rsrc_s[{off_r, 3'b000} +: 32], size_r, uns_r);
    end

    // Request/access/response sequencer with registered bus and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            ce_r         <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            sel_r        <= 4'b0000;
            data_r       <= 32'h0000_0000;
            split_r      <= 1'b0;
            size_r       <= 2'b00;
            uns_r        <= 1'b0;
            off_r        <= 2'b00;
            addr1_r      <= '0;
            sel1_r       <= 4'b0000;
            data1_r      <= 32'h0000_0000;
            first_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                    if (bus.req_valid_i) begin
                        ready_r <= 1'b0;
                        split_r <= split_s;
                        size_r  <= bus.req_size_i;
                        uns_r   <= bus.req_unsigned_i;
                        off_r   <= off_s;
                        addr1_r <= word_addr_s + ADDR_W'(4);
                        sel1_r  <= sel_wide_s[7:4];
                        data1_r <= bus.req_we_i ? wshift_s[63:32] : 32'h0000_0000;
                        if (err_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else begin
                            state_r <= ACC0;
                            ce_r    <= 1'b1;
                            we_r    <= bus.req_we_i;
                            addr_r  <= word_addr_s;
                            sel_r   <= sel_wide_s[3:0];
                            data_r  <= bus.req_we_i ? wdata0_s : 32'h0000_0000;
                        end
                    end
                end
                ACC0: begin
                    if (we_r || bus.rvalid_i) begin
                        if (split_r) begin
                            state_r <= ACC1;
                            addr_r  <= addr1_r;
                            sel_r   <= sel1_r;
                            data_r  <= data1_r;
                            first_r <= bus.data_i;
                        end else begin
                            state_r      <= RESP;
                            ce_r         <= 1'b0;
                            we_r         <= 1'b0;
                            addr_r       <= '0;
                            sel_r        <= 4'b0000;
                            data_r       <= 32'h0000_0000;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= we_r ? 32'h0000_0000 : load_s;
                        end
                    end
                end
                ACC1: begin
                    if (we_r || bus.rvalid_i) begin
                        state_r      <= RESP;
                        ce_r         <= 1'b0;
                        we_r         <= 1'b0;
                        addr_r       <= '0;
                        sel_r        <= 4'b0000;
                        data_r       <= 32'h0000_0000;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= we_r ? 32'h0000_0000 : load_s;
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                    ce_r         <= 1'b0;
                    we_r         <= 1'b0;
                    addr_r       <= '0;
                    sel_r        <= 4'b0000;
                    data_r       <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = ready_r;
    assign bus.resp_valid_o = resp_valid_r;
    assign bus.resp_rdata_o = resp_rdata_r;
    assign bus.resp_err_o   = resp_err_r;
    assign bus.ce_o         = ce_r;
    assign bus.we_o         = we_r;
    assign bus.addr_o       = addr_r;
    assign bus.sel_o        = sel_r;
    assign bus.data_o       = data_r;
endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Initiator side of the data-memory port: accepts one load/store request at a time from the pipeline's memory stage and drives the RAM data interface (ce/addr/we/sel/data, rvalid/rdata). It generates byte-enable masks, replicates store data, and extracts and sign- or zero-extends load data. It also detects misaligned accesses and returns a single-cycle response with rdata or an error flag.

## Interface
- ADDR_W, 32, byte-address width of request and bus address
- clk_i  in  1  clock; all state changes on posedge
- rst_i  in  1  reset, synchronous, active-high (one clock domain, no async reset)
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept request (high only in IDLE)
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal and returns an error
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  store data, right-aligned
- resp_valid_o  out  1  one-cycle response strobe
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  misaligned or illegal-size access; no bus access performed
- ce_o  out  1  bus chip enable
- we_o  out  1  bus write enable
- addr_o  out  ADDR_W  bus address, always word-aligned (bits [1:0] = 0)
- sel_o  out  4  byte enables; bit n covers data[8n+7:8n]
- data_o  out  32  bus write data
- rvalid_i  in  1  read data valid; the RAM drives it combinationally in the same cycle
- data_i  in  32  bus read data, combinational

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE → ACC0 on req_valid_i, capturing all request fields. IDLE → RESP directly on an error.
- ACC0/ACC1 drive ce_o=1 plus we_o, addr_o, sel_o and data_o from registers.
- Stores complete in one ACCx cycle. Loads complete when rvalid_i=1; otherwise the block stays in the state and re-drives the same signals (wait state).
- ACC0 → ACC1 when the access is split; otherwise ACC0 → RESP. ACC1 → RESP. RESP → IDLE unconditionally.
- off = addr[1:0]; nbytes = 1/2/4; mask = 0001/0011/1111.
- Single access: sel_o = mask << off; addr_o = {addr[ADDR_W-1:2],2'b00}.
- Store data: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata. In the split case, data comes from the low/high halves of {32'b0,wdata} << 8*off.
- Load data: first-access data_i >> 8*off, truncated to nbytes, then extended per req_unsigned_i. In the split case, use {second,first} >> 8*off.
- Response registers are cleared in IDLE. Stores return rdata=0.

## Timing
- Reset values: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, ce_o=0, we_o=0, addr_o=0, sel_o=0, data_o=0; FSM in IDLE.
- Latency with no wait states: request accepted at edge N; bus active during cycle N+1; resp_valid_o high during cycle N+2; next request can be accepted at edge N+3.
- Split access adds 1 cycle. Error responses arrive 1 cycle after acceptance.
- No response backpressure: resp_valid_o is high for exactly one cycle.
- Bus outputs are registered and are 0 whenever ce_o=0.
- Reset asserted in any state: the next edge forces IDLE and all outputs go to reset values. An in-flight write on that same edge is still seen by the RAM.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined:
  - Half at off 1 uses sel 0110 in one access.
  - Accesses with off+nbytes>4 are split into ACC0 at word A with sel = (mask<<off)[3:0], then ACC1 at A+4 with sel = mask>>(4-off).
  - Only illegal size errors.
- Undefined: any half with off[0]=1 or word with off≠0 gives resp_err_o=1 and no bus activity; ACC1 is unreachable.

## Test plan
- After reset, a word store of 0xDEADBEEF at 0x100 → bus cycle with addr 0x100, sel 1111; a word load from 0x100 returns 0xDEADBEEF 2 cycles after acceptance.
- Byte load from 0x103 with mem word 0x80FF0000, signed → 0xFFFFFF80; unsigned → 0x00000080.
- Half store 0xABCD at 0x102 → sel 1100, data_o 0xABCDABCD; a follow-up word load returns 0xABCDxxxx with the lower half unchanged.
- Word load at 0x101:
  - Without the macro → resp_err_o=1, ce_o never high.
  - With the macro, where 0x100=0x44332211 and 0x104=0x88776655 → two bus cycles (0x100 sel 1110, then 0x104 sel 0001) and rdata 0x55443322.
- Hold rvalid_i=0 for 3 cycles during a load → ACC0 is held with stable outputs and the response arrives 3 cycles late with correct data.
- Assert rst_i during ACC0 of a load → the next cycle has ce_o=0, resp_valid_o=0, req_ready_o=1, and no response is emitted.
